// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory: size encodings, FSM states,
// default geometry and the alignment helpers used by the controller.
package data_memory_ctrl_pkg;

   localparam int DMEM_DEPTH_WORDS = 64;
   localparam int DMEM_ADDR_W      = $clog2(DMEM_DEPTH_WORDS);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   // Reserved size 2'b11 behaves as a word access everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return off[0];
         default:   return off != 2'b00;
      endcase
   endfunction

   function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return off;
         SIZE_HALF: return {off[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface data_memory_ctrl_if;

   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
   logic        misalign_err;

   modport master (
      output mem_read, mem_write, size, load_unsigned, addr, write_data,
      input  read_data, stall, misalign_err
   );

   modport slave (
      input  mem_read, mem_write, size, load_unsigned, addr, write_data,
      output read_data, stall, misalign_err
   );

endinterface

// File: rtl/data_memory_ctrl_mem_lane_align.sv
// Little-endian byte-lane merge for stores and lane select plus sign/zero extension for loads.
module mem_lane_align
   import data_memory_ctrl_pkg::*;
(
   input  logic [31:0] stored_word,
   input  logic [31:0] new_data,
   input  logic [1:0]  size,
   input  logic [1:0]  byte_off,
   input  logic        load_unsigned,
   output logic [31:0] store_word,
   output logic [31:0] load_word
);

   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   always_comb begin
      store_word = stored_word;
      load_word  = stored_word;
      lane_b     = stored_word[{byte_off, 3'b000} +: 8];
      lane_h     = stored_word[{byte_off[1], 4'b0000} +: 16];
      case (size)
         SIZE_BYTE: begin
            store_word[{byte_off, 3'b000} +: 8] = new_data[7:0];
            load_word = load_unsigned ? {24'd0, lane_b} : 32'(lane_b);
         end
         SIZE_HALF: begin
            store_word[{byte_off[1], 4'b0000} +: 16] = new_data[15:0];
            load_word = load_unsigned ? {16'd0, lane_h} : 32'(lane_h);
         end
         default: begin
            store_word = new_data;
            load_word  = stored_word;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory with a fixed-latency request handshake and pipeline stall.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module data_memory_ctrl
   import data_memory_ctrl_pkg::*;
#(
   parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
   parameter int LATENCY     = 2
) (
   input logic              clk,
   input logic              rst_n,
   data_memory_ctrl_if.slave bus
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q;
   logic [31:0] rdata_q;

   logic [IDX_W+1:0] addr_p0;
   logic [31:0]      data_p0;
   logic [1:0]       size_p0;
   logic             uns_p0, rd_p0, wr_p0;

   logic [IDX_W+1:0] eff_addr;
   logic [31:0]      eff_data;
   logic [1:0]       eff_size, lane_off;
   logic             eff_uns, eff_rd, eff_wr;
   logic             req, accept, commit, blocked;
   logic [IDX_W-1:0] idx;
   logic [31:0]      store_word, load_word;

   logic [31:0] mem [DEPTH_WORDS];

   assign req    = bus.mem_read | bus.mem_write;
   assign accept = (state_q == IDLE) && req;
   assign commit = (accept && LATENCY == 1) || (state_q == BUSY && cnt_q == 4'd1);

   // With LATENCY==1 the commit edge is the accept edge, so live inputs feed the datapath.
   always_comb begin
      if (state_q == IDLE) begin
         eff_addr = bus.addr[IDX_W+1:0];
         eff_data = bus.write_data;
         eff_size = bus.size;
         eff_uns  = bus.load_unsigned;
         eff_rd   = bus.mem_read;
         eff_wr   = bus.mem_write;
      end else begin
         eff_addr = addr_p0;
         eff_data = data_p0;
         eff_size = size_p0;
         eff_uns  = uns_p0;
         eff_rd   = rd_p0;
         eff_wr   = wr_p0;
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign lane_off = eff_addr[1:0];
   assign blocked  = is_misaligned(eff_size, eff_addr[1:0]);
`else
   assign lane_off = align_off(eff_size, eff_addr[1:0]);
   assign blocked  = 1'b0;
`endif

   assign idx = eff_addr[IDX_W+1:2];

   mem_lane_align u_lane_align (
      .stored_word  (mem[idx]),
      .new_data     (eff_data),
      .size         (eff_size),
      .byte_off     (lane_off),
      .load_unsigned(eff_uns),
      .store_word   (store_word),
      .load_word    (load_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = (LATENCY == 1) ? DONE : BUSY;
         BUSY:    if (cnt_q == 4'd1) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept)
            cnt_q <= CNT_LOAD;
         else if (state_q == BUSY)
            cnt_q <= cnt_q - 4'd1;
         if (commit && eff_rd && !eff_wr && !blocked)
            rdata_q <= load_word;
      end
   end

   // Request capture (data path, no reset)
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0 <= bus.addr[IDX_W+1:0];
         data_p0 <= bus.write_data;
         size_p0 <= bus.size;
         uns_p0  <= bus.load_unsigned;
         rd_p0   <= bus.mem_read;
         wr_p0   <= bus.mem_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && commit && eff_wr && !blocked)
         mem[idx] <= store_word;
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic mis_q;
   always_ff @(posedge clk) begin
      if (!rst_n) mis_q <= 1'b0;
      else        mis_q <= commit & blocked;
   end
   assign bus.misalign_err = mis_q;
`else
   assign bus.misalign_err = 1'b0;
`endif

   assign bus.stall     = accept | (state_q == BUSY);
   assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against a byte-level memory model.
module tb_data_memory_ctrl;
   import data_memory_ctrl_pkg::*;

   localparam int LATENCY = 2;
   localparam int DEPTH   = 64;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   data_memory_ctrl_if bus ();

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] ref_rd;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Behavioural model: memory as bytes, access width in bytes, wrap by modulo.
   task automatic ref_access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] d, output bit exp_mis);
      int unsigned wi, off, nbytes;
      logic [31:0] w, v;
      wi     = (a / 4) % DEPTH;
      off    = a % 4;
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      exp_mis = 1'b0;
      if ((off % nbytes) != 0 && TRAP) begin
         exp_mis = 1'b1;
         return;
      end
      off = off - (off % nbytes);
      w = ref_mem[wi];
      if (wr) begin
         for (int k = 0; k < nbytes; k++) w[8*(off+k) +: 8] = d[8*k +: 8];
         ref_mem[wi] = w;
      end else if (rd) begin
         v = 32'd0;
         for (int k = 0; k < nbytes; k++) v[8*k +: 8] = w[8*(off+k) +: 8];
         if (!uns && nbytes < 4 && v[8*nbytes-1])
            for (int k = 8*nbytes; k < 32; k++) v[k] = 1'b1;
         ref_rd = v;
      end
   endtask

   task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d, input string tag);
      int n;
      bit e_mis;
      ref_access(rd, wr, sz, uns, a, d, e_mis);
      @(negedge clk);
      bus.mem_read = rd; bus.mem_write = wr; bus.size = sz;
      bus.load_unsigned = uns; bus.addr = a; bus.write_data = d;
      #1 check_eq({tag, " stall_req"}, 32'(bus.stall), 32'd1);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (bus.stall && n < 40);
      check_eq({tag, " latency"}, n, LATENCY);
      check_eq({tag, " read_data"}, bus.read_data, ref_rd);
      check_eq({tag, " misalign_done"}, 32'(bus.misalign_err), 32'(e_mis));
      @(negedge clk);
      bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, " misalign_after"}, 32'(bus.misalign_err), 32'd0);
      check_eq({tag, " stall_idle"}, 32'(bus.stall), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r, w;
      rst_n = 1'b0;
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = SIZE_WORD;
      bus.load_unsigned = 1'b0; bus.addr = 32'd0; bus.write_data = 32'd0;
      ref_rd = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst read_data", bus.read_data, 32'd0);
      check_eq("rst stall", 32'(bus.stall), 32'd0);
      check_eq("rst misalign", 32'(bus.misalign_err), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, SIZE_WORD, 1'b0, 32'(i*4), $urandom, "init");

      access(0, 1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF, "t1 sw");
      access(1, 0, SIZE_WORD, 0, 32'h10, 32'h0, "t1 lw");

      access(0, 1, SIZE_WORD, 0, 32'h10, 32'h11223344, "t2 sw");
      access(0, 1, SIZE_BYTE, 0, 32'h11, 32'h000000A5, "t2 sb");
      access(1, 0, SIZE_WORD, 0, 32'h10, 32'h0, "t2 lw");
      check_eq("t2 merged", bus.read_data, 32'h1122A544);
      access(1, 0, SIZE_BYTE, 0, 32'h11, 32'h0, "t2 lb");
      check_eq("t2 lb value", bus.read_data, 32'hFFFFFFA5);
      access(1, 0, SIZE_BYTE, 1, 32'h11, 32'h0, "t2 lbu");
      check_eq("t2 lbu value", bus.read_data, 32'h000000A5);

      access(0, 1, SIZE_HALF, 0, 32'h12, 32'h00008001, "t3 sh");
      access(1, 0, SIZE_HALF, 0, 32'h12, 32'h0, "t3 lh");
      check_eq("t3 lh value", bus.read_data, 32'hFFFF8001);
      access(1, 0, SIZE_HALF, 1, 32'h12, 32'h0, "t3 lhu");
      access(1, 0, SIZE_WORD, 0, 32'h10, 32'h0, "t3 lw");
      check_eq("t3 word", bus.read_data, 32'h8001A544);

      access(1, 1, SIZE_WORD, 0, 32'h20, 32'h55, "t4 rw");
      access(1, 0, SIZE_WORD, 0, 32'h20, 32'h0, "t4 lw");
      access(0, 1, SIZE_WORD, 0, 32'h100, 32'hCAFEF00D, "t4 alias sw");
      access(1, 0, SIZE_WORD, 0, 32'h0, 32'h0, "t4 alias lw");
      check_eq("t4 alias value", bus.read_data, 32'hCAFEF00D);

      // Reset while the store is in BUSY: the write must be dropped.
      @(negedge clk);
      bus.mem_write = 1'b1; bus.size = SIZE_WORD; bus.addr = 32'h30; bus.write_data = 32'h1234;
      @(posedge clk); #1;
      check_eq("t5 busy stall", 32'(bus.stall), 32'd1);
      rst_n = 1'b0; bus.mem_write = 1'b0;
      @(posedge clk); #1;
      check_eq("t5 stall", 32'(bus.stall), 32'd0);
      check_eq("t5 read_data", bus.read_data, 32'd0);
      ref_rd = 32'd0;
      @(negedge clk) rst_n = 1'b1;
      access(1, 0, SIZE_WORD, 0, 32'h30, 32'h0, "t5 lw");

      access(1, 0, SIZE_WORD, 0, 32'h13, 32'h0, "t6 lw mis");
      access(0, 1, SIZE_HALF, 0, 32'h23, 32'hBEEF, "t6 sh mis");
      access(1, 0, SIZE_WORD, 0, 32'h20, 32'h0, "t6 lw chk");
      access(1, 0, 2'b11, 1, 32'h24, 32'h0, "t6 reserved");

      for (int i = 0; i < 300; i++) begin
         r = 1'($urandom);
         w = 1'($urandom);
         if (!r && !w) r = 1'b1;
         access(r, w, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom, "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
